control_word_sequencer: RTL and testbench
=========================================

Name: control_word_sequencer

Overview:
Consumer end of the 33-bit control-word interface the instruction decoders produce (cw_IW plus K). The block holds the instruction register, the 2-bit execute state and the 5-bit status register that feed back into the decoders. It fetches instructions, unpacks each control word into datapath strobes, gates all side effects to legal cycles and stalls on slow RAM. It sits between the decoder mux and the datapath (ALU, register file, RAM, PC).

Parameters:
CNT_W, 32, width of the retired-instruction counter
FETCH_PC_FS, 2'b01, PC function select used for the fetch-phase PC+4

Ports:
clock  in  1  system clock; all state updates on the rising edge
reset_n  in  1  asynchronous, active-low reset
instr_in  in  32  instruction word from instruction memory
instr_valid  in  1  instr_in is valid this cycle
fetch_req  out  1  request the next instruction at the current PC
I  out  32  instruction register, driven to the decoders
state  out  2  execute state, driven to the decoders
status  out  5  status register, driven to the decoders
cw_in  in  33  selected decoder control word {alu_en, alu_bs, alu_fs[4:0], rf_b_en, rf_sa, rf_sb, rf_da, rf_w, ram_en, ram_w, pc_en, pc_fs, pc_is, status_ld, next_state}
K_in  in  64  selected decoder constant
status_in  in  5  ALU flags
ram_ready  in  1  RAM access completes this cycle
alu_en, alu_bs, alu_fs[5], rf_b_en, rf_sa[5], rf_sb[5], rf_da[5], rf_w, ram_en, ram_w, pc_en, pc_fs[2], pc_is  out  datapath strobes
K  out  64  constant to the datapath
retired  out  CNT_W  count of completed instructions

Behaviour:
- FSM phases: FETCH, EXEC. On reset: phase = FETCH; I = 32'b0; state = 2'b00; status = 5'b0; retired = 0.
- While reset_n is low, all outputs are forced to 0.
- FETCH:
  - fetch_req = 1.
  - All datapath write strobes = 0 (rf_w, ram_w, ram_en, status_ld, alu_en, rf_b_en, pc_is). pc_en = 0.
  - When instr_valid = 1: I <= instr_in, state <= 2'b00, phase <= EXEC. pc_fs = FETCH_PC_FS is driven and pc_en = 1 only in that cycle (PC+4).
  - With instr_valid = 0, FETCH holds indefinitely with no side effects.
- EXEC:
  - fetch_req = 0. All cw fields pass combinationally from cw_in to the outputs, and K = K_in.
  - Stall: when ram_en = 1 and ram_ready = 0, the cycle is held. rf_w, ram_w, pc_en and status_ld are forced to 0, no register updates, and other fields are driven unchanged.
  - Non-stall cycle with status_ld = 1: status <= status_in at the clock edge.
  - next_state != 00: state <= next_state; remain in EXEC.
  - next_state == 00: phase <= FETCH; state <= 00; retired <= retired + 1, wrapping modulo 2^CNT_W.
  - Multi-cycle instructions are unbounded by design; a next_state loop is the decoder's responsibility.
- ram_ready rising in the same cycle as next_state == 00: the access completes, strobes are issued and the sequencer goes to FETCH in the same edge.
- Reset asserted mid-EXEC or mid-stall: immediate return to the reset values; the partial instruction is dropped and not counted.
- Latency: a single-cycle instruction takes 1 FETCH cycle (with instr_valid high) plus 1 EXEC cycle.

Decomposition:
- Shared package: phase encoding, 33-bit cw bit-position constants (field offsets), FETCH_PC_FS and the PC function codes.
- One natural sub-module: cw_unpack, a combinational slice-and-gate of cw_in with a suppress input. The FSM, IR, status register and counter stay in the top.

Test Plan:
1. Reset then instr_valid = 1 with instr_in = 32'h9100_0421 → fetch_req = 1 in the first cycle; next cycle I = 32'h9100_0421, state = 00, pc_en = 1 with pc_fs = 01 during the fetch cycle only.
2. EXEC, cw_in next_state = 00, rf_w = 1, rf_da = 5'd3 → rf_w = 1 for exactly one cycle, then fetch_req = 1 and retired = 1.
3. Branch-type cw (pc_en = 1, pc_fs = 10, pc_is = 1, rf_w = 0, ram_en = 0) → one EXEC cycle, outputs match the fields exactly, status unchanged.
4. cw with ram_en = 1, ram_w = 1 and ram_ready held low 3 cycles → ram_w = 0 and state frozen for 3 cycles; ram_w = 1 in the cycle ram_ready = 1, then FETCH.
5. cw status_ld = 1, status_in = 5'b10101, next_state = 01, then second cw next_state = 00 → status = 5'b10101; state goes 00 → 01 → FETCH; retired increments once.
6. reset_n pulsed low mid-stall → all outputs 0 asynchronously; after release, FETCH with retired = 0. Separately, preload retired to all ones and retire one instruction → retired wraps to 0.

Source files
------------

// File: rtl/control_word_sequencer_pkg.sv
// Shared definitions for the control-word sequencer: phase encoding, the 33-bit
// control-word field offsets, the PC function codes and the unpacked field struct.
package control_word_sequencer_pkg;

    localparam int CW_W = 33;

    localparam logic [0:0] PH_FETCH = 1'b0;
    localparam logic [0:0] PH_EXEC  = 1'b1;

    // Bit offsets into cw_in, LSB first.
    localparam int CW_NS_LSB     = 0;
    localparam int CW_STATUS_LD  = 2;
    localparam int CW_PC_IS      = 3;
    localparam int CW_PC_FS_LSB  = 4;
    localparam int CW_PC_EN      = 6;
    localparam int CW_RAM_W      = 7;
    localparam int CW_RAM_EN     = 8;
    localparam int CW_RF_W       = 9;
    localparam int CW_RF_DA_LSB  = 10;
    localparam int CW_RF_SB_LSB  = 15;
    localparam int CW_RF_SA_LSB  = 20;
    localparam int CW_RF_B_EN    = 25;
    localparam int CW_ALU_FS_LSB = 26;
    localparam int CW_ALU_BS     = 31;
    localparam int CW_ALU_EN     = 32;

    localparam logic [1:0] PC_FS_HOLD   = 2'b00;
    localparam logic [1:0] PC_FS_INC4   = 2'b01;
    localparam logic [1:0] PC_FS_BRANCH = 2'b10;
    localparam logic [1:0] PC_FS_REG    = 2'b11;

    localparam logic [1:0] FETCH_PC_FS = PC_FS_INC4;

    typedef struct packed {
        logic       alu_en;
        logic       alu_bs;
        logic [4:0] alu_fs;
        logic       rf_b_en;
        logic [4:0] rf_sa;
        logic [4:0] rf_sb;
        logic [4:0] rf_da;
        logic       rf_w;
        logic       ram_en;
        logic       ram_w;
        logic       pc_en;
        logic [1:0] pc_fs;
        logic       pc_is;
        logic       status_ld;
        logic [1:0] next_state;
    } cw_fields_t;

endpackage

// File: rtl/control_word_sequencer_if.sv
// Decoder/datapath bundle seen by the sequencer: instruction fetch, control word in,
// feedback to the decoders and the unpacked datapath strobes out.
interface control_word_sequencer_if #(parameter int CNT_W = 32);
    logic [31:0]      instr_in;
    logic             instr_valid;
    logic             fetch_req;
    logic [31:0]      I;
    logic [1:0]       state;
    logic [4:0]       status;
    logic [32:0]      cw_in;
    logic [63:0]      K_in;
    logic [4:0]       status_in;
    logic             ram_ready;
    logic             alu_en;
    logic             alu_bs;
    logic [4:0]       alu_fs;
    logic             rf_b_en;
    logic [4:0]       rf_sa;
    logic [4:0]       rf_sb;
    logic [4:0]       rf_da;
    logic             rf_w;
    logic             ram_en;
    logic             ram_w;
    logic             pc_en;
    logic [1:0]       pc_fs;
    logic             pc_is;
    logic [63:0]      K;
    logic [CNT_W-1:0] retired;

    modport slave (
        input  instr_in, instr_valid, cw_in, K_in, status_in, ram_ready,
        output fetch_req, I, state, status,
        output alu_en, alu_bs, alu_fs, rf_b_en, rf_sa, rf_sb, rf_da, rf_w,
        output ram_en, ram_w, pc_en, pc_fs, pc_is, K, retired
    );

    modport master (
        output instr_in, instr_valid, cw_in, K_in, status_in, ram_ready,
        input  fetch_req, I, state, status,
        input  alu_en, alu_bs, alu_fs, rf_b_en, rf_sa, rf_sb, rf_da, rf_w,
        input  ram_en, ram_w, pc_en, pc_fs, pc_is, K, retired
    );
endinterface

// File: rtl/control_word_sequencer_cw_unpack.sv
// Combinational slice of the 33-bit control word into fields; zero outside EXEC and,
// on a RAM stall, the side-effecting strobes are suppressed while addresses stay driven.
module control_word_sequencer_cw_unpack
    import control_word_sequencer_pkg::*;
(
    input  logic [CW_W-1:0] cw_in,
    input  logic            enable,
    input  logic            suppress,
    output cw_fields_t      cw
);

    always_comb begin
        cw = '0;
        if (enable) begin
            cw.alu_en     = cw_in[CW_ALU_EN];
            cw.alu_bs     = cw_in[CW_ALU_BS];
            cw.alu_fs     = cw_in[CW_ALU_FS_LSB +: 5];
            cw.rf_b_en    = cw_in[CW_RF_B_EN];
            cw.rf_sa      = cw_in[CW_RF_SA_LSB +: 5];
            cw.rf_sb      = cw_in[CW_RF_SB_LSB +: 5];
            cw.rf_da      = cw_in[CW_RF_DA_LSB +: 5];
            cw.rf_w       = cw_in[CW_RF_W];
            cw.ram_en     = cw_in[CW_RAM_EN];
            cw.ram_w      = cw_in[CW_RAM_W];
            cw.pc_en      = cw_in[CW_PC_EN];
            cw.pc_fs      = cw_in[CW_PC_FS_LSB +: 2];
            cw.pc_is      = cw_in[CW_PC_IS];
            cw.status_ld  = cw_in[CW_STATUS_LD];
            cw.next_state = cw_in[CW_NS_LSB +: 2];
            if (suppress) begin
                cw.rf_w      = 1'b0;
                cw.ram_w     = 1'b0;
                cw.pc_en     = 1'b0;
                cw.status_ld = 1'b0;
            end
        end
    end

endmodule

// File: rtl/control_word_sequencer.sv
// Fetch/execute sequencer: holds IR, execute state, status and retired count, and turns
// the selected decoder control word into gated datapath strobes.
module control_word_sequencer
    import control_word_sequencer_pkg::*;
#(
    parameter int         CNT_W       = 32,
    parameter logic [1:0] FETCH_PC_FS = control_word_sequencer_pkg::FETCH_PC_FS
) (
    input  logic                     clock,
    input  logic                     reset_n,
    control_word_sequencer_if.slave  bus
);

    logic [0:0]       phase_q, phase_d;
    logic [31:0]      i_q, i_d;
    logic [1:0]       state_q, state_d;
    logic [4:0]       status_q, status_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic       in_fetch;
    logic       exec_en;
    logic       stall;
    logic       fetch_take;
    cw_fields_t cw;

    // Outputs are gated by reset_n so they drop to zero the moment reset asserts.
    assign in_fetch   = reset_n && (phase_q == PH_FETCH);
    assign exec_en    = reset_n && (phase_q == PH_EXEC);
    assign stall      = exec_en && bus.cw_in[CW_RAM_EN] && !bus.ram_ready;
    assign fetch_take = in_fetch && bus.instr_valid;

    control_word_sequencer_cw_unpack u_cw_unpack (
        .cw_in    (bus.cw_in),
        .enable   (exec_en),
        .suppress (stall),
        .cw       (cw)
    );

    always_comb begin
        phase_d   = phase_q;
        i_d       = i_q;
        state_d   = state_q;
        status_d  = status_q;
        retired_d = retired_q;
        if (phase_q == PH_FETCH) begin
            if (bus.instr_valid) begin
                i_d     = bus.instr_in;
                state_d = 2'b00;
                phase_d = PH_EXEC;
            end
        end else if (!stall) begin
            if (cw.status_ld) begin
                status_d = bus.status_in;
            end
            if (cw.next_state != 2'b00) begin
                state_d = cw.next_state;
            end else begin
                phase_d   = PH_FETCH;
                state_d   = 2'b00;
                retired_d = retired_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            phase_q   <= PH_FETCH;
            i_q       <= '0;
            state_q   <= '0;
            status_q  <= '0;
            retired_q <= '0;
        end else begin
            phase_q   <= phase_d;
            i_q       <= i_d;
            state_q   <= state_d;
            status_q  <= status_d;
            retired_q <= retired_d;
        end
    end

    assign bus.fetch_req = in_fetch;
    assign bus.I         = i_q;
    assign bus.state     = state_q;
    assign bus.status    = status_q;
    assign bus.retired   = retired_q;

    assign bus.alu_en  = cw.alu_en;
    assign bus.alu_bs  = cw.alu_bs;
    assign bus.alu_fs  = cw.alu_fs;
    assign bus.rf_b_en = cw.rf_b_en;
    assign bus.rf_sa   = cw.rf_sa;
    assign bus.rf_sb   = cw.rf_sb;
    assign bus.rf_da   = cw.rf_da;
    assign bus.rf_w    = cw.rf_w;
    assign bus.ram_en  = cw.ram_en;
    assign bus.ram_w   = cw.ram_w;
    // The fetch cycle borrows the PC strobes to advance PC by 4.
    assign bus.pc_en   = cw.pc_en | fetch_take;
    assign bus.pc_fs   = fetch_take ? FETCH_PC_FS : cw.pc_fs;
    assign bus.pc_is   = cw.pc_is;
    assign bus.K       = exec_en ? bus.K_in : 64'd0;

endmodule

// File: tb/tb_control_word_sequencer.sv
// Directed bench for control_word_sequencer: fetch, single/multi-cycle execute,
// RAM stall, async reset mid-stall and retired-counter wrap on a narrow instance.
module tb_control_word_sequencer;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset_n;
    logic reset_w_n;

    control_word_sequencer_if #(.CNT_W(32)) bus ();
    control_word_sequencer_if #(.CNT_W(2))  bus_w ();

    control_word_sequencer #(.CNT_W(32), .FETCH_PC_FS(2'b01)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    control_word_sequencer #(.CNT_W(2), .FETCH_PC_FS(2'b01)) dut_w (
        .clock   (clock),
        .reset_n (reset_w_n),
        .bus     (bus_w)
    );

    int checks = 0;
    int errors = 0;

    task automatic drive_idle();
        bus.instr_in    = '0;
        bus.instr_valid = 1'b0;
        bus.cw_in       = '0;
        bus.K_in        = '0;
        bus.status_in   = '0;
        bus.ram_ready   = 1'b0;
    endtask

    // Presents one instruction for a single FETCH cycle; returns at the first EXEC negedge.
    task automatic do_fetch(input logic [31:0] w);
        @(negedge clock);
        bus.instr_in    = w;
        bus.instr_valid = 1'b1;
        @(negedge clock);
        bus.instr_valid = 1'b0;
        bus.instr_in    = '0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive_idle();
        bus.instr_valid = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        checks++; if (bus.fetch_req !== 1'b0) begin errors++; $display("FAIL rst_fetch_req got %0b want 0", bus.fetch_req); end
        checks++; if (bus.pc_en !== 1'b0) begin errors++; $display("FAIL rst_pc_en got %0b want 0", bus.pc_en); end
        checks++; if (bus.I !== 32'h0) begin errors++; $display("FAIL rst_I got %h want 0", bus.I); end
        checks++; if (bus.retired !== 32'd0) begin errors++; $display("FAIL rst_retired got %0d want 0", bus.retired); end
        @(negedge clock);
        reset_n = 1'b1;
        bus.instr_valid = 1'b0;
        #1;
        checks++; if (bus.fetch_req !== 1'b1) begin errors++; $display("FAIL post_rst_fetch_req got %0b want 1", bus.fetch_req); end
        checks++; if (bus.pc_en !== 1'b0) begin errors++; $display("FAIL idle_fetch_pc_en got %0b want 0", bus.pc_en); end
    endtask

    task automatic test_fetch();
        @(negedge clock);
        bus.instr_in    = 32'h9100_0421;
        bus.instr_valid = 1'b1;
        #1;
        checks++; if (bus.fetch_req !== 1'b1) begin errors++; $display("FAIL fetch_req got %0b want 1", bus.fetch_req); end
        checks++; if (bus.pc_en !== 1'b1) begin errors++; $display("FAIL fetch_pc_en got %0b want 1", bus.pc_en); end
        checks++; if (bus.pc_fs !== 2'b01) begin errors++; $display("FAIL fetch_pc_fs got %b want 01", bus.pc_fs); end
        checks++; if (bus.rf_w !== 1'b0) begin errors++; $display("FAIL fetch_rf_w got %0b want 0", bus.rf_w); end
        @(negedge clock);
        bus.instr_valid = 1'b0;
        bus.instr_in    = '0;
        #1;
        checks++; if (bus.I !== 32'h9100_0421) begin errors++; $display("FAIL ir_load got %h want 91000421", bus.I); end
        checks++; if (bus.state !== 2'b00) begin errors++; $display("FAIL exec_state got %b want 00", bus.state); end
        checks++; if (bus.fetch_req !== 1'b0) begin errors++; $display("FAIL exec_fetch_req got %0b want 0", bus.fetch_req); end
        checks++; if (bus.pc_en !== 1'b0) begin errors++; $display("FAIL exec_pc_en got %0b want 0", bus.pc_en); end
    endtask

    task automatic test_single_cycle();
        bus.cw_in = 33'h0_0000_0E00;
        bus.K_in  = 64'hDEAD_BEEF_0123_4567;
        #1;
        checks++; if (bus.rf_w !== 1'b1) begin errors++; $display("FAIL sc_rf_w got %0b want 1", bus.rf_w); end
        checks++; if (bus.rf_da !== 5'd3) begin errors++; $display("FAIL sc_rf_da got %0d want 3", bus.rf_da); end
        checks++; if (bus.K !== 64'hDEAD_BEEF_0123_4567) begin errors++; $display("FAIL sc_K got %h want deadbeef01234567", bus.K); end
        @(negedge clock);
        bus.cw_in = '0;
        bus.K_in  = '0;
        #1;
        checks++; if (bus.rf_w !== 1'b0) begin errors++; $display("FAIL sc_rf_w_after got %0b want 0", bus.rf_w); end
        checks++; if (bus.fetch_req !== 1'b1) begin errors++; $display("FAIL sc_fetch_req got %0b want 1", bus.fetch_req); end
        checks++; if (bus.retired !== 32'd1) begin errors++; $display("FAIL sc_retired got %0d want 1", bus.retired); end
    endtask

    task automatic test_branch();
        do_fetch(32'h1400_0010);
        bus.cw_in     = 33'h1_4870_0068;
        bus.status_in = 5'b11111;
        #1;
        checks++; if (bus.alu_en !== 1'b1) begin errors++; $display("FAIL br_alu_en got %0b want 1", bus.alu_en); end
        checks++; if (bus.alu_fs !== 5'h12) begin errors++; $display("FAIL br_alu_fs got %h want 12", bus.alu_fs); end
        checks++; if (bus.rf_sa !== 5'd7) begin errors++; $display("FAIL br_rf_sa got %0d want 7", bus.rf_sa); end
        checks++; if (bus.pc_en !== 1'b1) begin errors++; $display("FAIL br_pc_en got %0b want 1", bus.pc_en); end
        checks++; if (bus.pc_fs !== 2'b10) begin errors++; $display("FAIL br_pc_fs got %b want 10", bus.pc_fs); end
        checks++; if (bus.pc_is !== 1'b1) begin errors++; $display("FAIL br_pc_is got %0b want 1", bus.pc_is); end
        checks++; if (bus.rf_w !== 1'b0 || bus.ram_en !== 1'b0) begin errors++; $display("FAIL br_quiet got rf_w=%0b ram_en=%0b want 0 0", bus.rf_w, bus.ram_en); end
        @(negedge clock);
        bus.cw_in     = '0;
        bus.status_in = '0;
        #1;
        checks++; if (bus.fetch_req !== 1'b1) begin errors++; $display("FAIL br_fetch_req got %0b want 1", bus.fetch_req); end
        checks++; if (bus.status !== 5'b00000) begin errors++; $display("FAIL br_status got %b want 00000", bus.status); end
        checks++; if (bus.retired !== 32'd2) begin errors++; $display("FAIL br_retired got %0d want 2", bus.retired); end
    endtask

    task automatic test_ram_stall();
        do_fetch(32'hF800_0000);
        bus.cw_in     = 33'h0_0000_0180;
        bus.ram_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clock);
            #1;
            checks++; if (bus.ram_w !== 1'b0) begin errors++; $display("FAIL stall%0d_ram_w got %0b want 0", i, bus.ram_w); end
            checks++; if (bus.ram_en !== 1'b1) begin errors++; $display("FAIL stall%0d_ram_en got %0b want 1", i, bus.ram_en); end
            checks++; if (bus.fetch_req !== 1'b0 || bus.state !== 2'b00) begin errors++; $display("FAIL stall%0d_hold got fetch_req=%0b state=%b want 0 00", i, bus.fetch_req, bus.state); end
        end
        @(negedge clock);
        bus.ram_ready = 1'b1;
        #1;
        checks++; if (bus.ram_w !== 1'b1) begin errors++; $display("FAIL ready_ram_w got %0b want 1", bus.ram_w); end
        @(negedge clock);
        bus.ram_ready = 1'b0;
        bus.cw_in     = '0;
        #1;
        checks++; if (bus.fetch_req !== 1'b1) begin errors++; $display("FAIL ram_done_fetch got %0b want 1", bus.fetch_req); end
        checks++; if (bus.retired !== 32'd3) begin errors++; $display("FAIL ram_retired got %0d want 3", bus.retired); end
    endtask

    task automatic test_status_multi();
        do_fetch(32'h8B00_0000);
        bus.cw_in     = 33'h0_0000_0005;
        bus.status_in = 5'b10101;
        #1;
        checks++; if (bus.state !== 2'b00) begin errors++; $display("FAIL mc_state0 got %b want 00", bus.state); end
        @(negedge clock);
        bus.cw_in     = '0;
        bus.status_in = 5'b01010;
        #1;
        checks++; if (bus.status !== 5'b10101) begin errors++; $display("FAIL mc_status got %b want 10101", bus.status); end
        checks++; if (bus.state !== 2'b01) begin errors++; $display("FAIL mc_state1 got %b want 01", bus.state); end
        checks++; if (bus.fetch_req !== 1'b0) begin errors++; $display("FAIL mc_still_exec got %0b want 0", bus.fetch_req); end
        @(negedge clock);
        bus.status_in = '0;
        #1;
        checks++; if (bus.fetch_req !== 1'b1 || bus.state !== 2'b00) begin errors++; $display("FAIL mc_done got fetch_req=%0b state=%b want 1 00", bus.fetch_req, bus.state); end
        checks++; if (bus.status !== 5'b10101) begin errors++; $display("FAIL mc_status_kept got %b want 10101", bus.status); end
        checks++; if (bus.retired !== 32'd4) begin errors++; $display("FAIL mc_retired got %0d want 4", bus.retired); end
    endtask

    task automatic test_reset_mid_stall();
        do_fetch(32'hF800_0001);
        bus.cw_in     = 33'h0_0000_0180;
        bus.K_in      = 64'h1;
        bus.ram_ready = 1'b0;
        @(negedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        checks++; if (bus.fetch_req !== 1'b0 || bus.ram_en !== 1'b0 || bus.ram_w !== 1'b0) begin errors++; $display("FAIL arst_strobes got fetch_req=%0b ram_en=%0b ram_w=%0b want 0 0 0", bus.fetch_req, bus.ram_en, bus.ram_w); end
        checks++; if (bus.I !== 32'h0 || bus.state !== 2'b00) begin errors++; $display("FAIL arst_ir got I=%h state=%b want 0 00", bus.I, bus.state); end
        checks++; if (bus.status !== 5'b0) begin errors++; $display("FAIL arst_status got %b want 00000", bus.status); end
        checks++; if (bus.retired !== 32'd0) begin errors++; $display("FAIL arst_retired got %0d want 0", bus.retired); end
        checks++; if (bus.K !== 64'h0) begin errors++; $display("FAIL arst_K got %h want 0", bus.K); end
        @(negedge clock);
        reset_n   = 1'b1;
        bus.cw_in = '0;
        bus.K_in  = '0;
        #1;
        checks++; if (bus.fetch_req !== 1'b1) begin errors++; $display("FAIL arst_rel_fetch got %0b want 1", bus.fetch_req); end
        checks++; if (bus.retired !== 32'd0) begin errors++; $display("FAIL arst_rel_retired got %0d want 0", bus.retired); end
    endtask

    task automatic test_retired_wrap();
        logic [1:0] want [4];
        want[0] = 2'd1; want[1] = 2'd2; want[2] = 2'd3; want[3] = 2'd0;
        @(negedge clock);
        reset_w_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            bus_w.instr_in    = 32'hA000_0000 + 32'(i);
            bus_w.instr_valid = 1'b1;
            @(negedge clock);
            bus_w.instr_valid = 1'b0;
            @(negedge clock);
            #1;
            checks++; if (bus_w.retired !== want[i]) begin errors++; $display("FAIL wrap%0d_retired got %0d want %0d", i, bus_w.retired, want[i]); end
        end
        checks++; if (bus_w.fetch_req !== 1'b1) begin errors++; $display("FAIL wrap_fetch got %0b want 1", bus_w.fetch_req); end
    endtask

    initial begin
        reset_w_n         = 1'b0;
        bus_w.instr_in    = '0;
        bus_w.instr_valid = 1'b0;
        bus_w.cw_in       = '0;
        bus_w.K_in        = '0;
        bus_w.status_in   = '0;
        bus_w.ram_ready   = 1'b0;
        test_reset();
        test_fetch();
        test_single_cycle();
        test_branch();
        test_ram_stall();
        test_status_multi();
        test_reset_mid_stall();
        test_retired_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
